// File: rtl/cc_lives_pkg.sv
// Shared constants for the Frogger lives manager and HUD.
// State codes and default life-count limits.
package cc_lives_pkg;

    typedef enum logic [1:0] {
        ST_PLAYING  = 2'd0,
        ST_HIT      = 2'd1,
        ST_GAMEOVER = 2'd2
    } livesState_t;

    localparam int LIVES_INIT_DEFAULT = 3;
    localparam int LIVES_MAX_DEFAULT  = 7;

endpackage

// File: rtl/cc_edge_detector.sv
// One-bit rising-edge detector with synchronous active-high reset.
// History updates every cycle, so a held level yields a single pulse.
module cc_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 1'b0;
        end else begin
            hist <= level;
        end
    end

    assign pulse = level & ~hist;

endmodule

// File: rtl/cc_lives_manager.sv
// Registered life counter with respawn window, low-lives and game-over flags.
// Death/bonus are edge-triggered; restart reloads a new game while held.
module cc_lives_manager
    import cc_lives_pkg::*;
#(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int LIVES_INIT              = LIVES_INIT_DEFAULT,
    parameter int LIVES_MAX               = LIVES_MAX_DEFAULT,
    parameter int LOW_THRESHOLD           = 1,
    parameter int RESPAWN_CYCLES          = 25_000_000
) (
    input  logic                               CC_LIVES_MANAGER_CLOCK_50,
    input  logic                               CC_LIVES_MANAGER_RESET_InHigh,
    input  logic                               CC_LIVES_MANAGER_restart_InHigh,
    input  logic                               CC_LIVES_MANAGER_death_InHigh,
    input  logic                               CC_LIVES_MANAGER_bonus_InHigh,
    output logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_MANAGER_lives_Out,
    output logic                               CC_LIVES_MANAGER_alive_OutHigh,
    output logic                               CC_LIVES_MANAGER_low_OutHigh,
    output logic                               CC_LIVES_MANAGER_respawn_OutHigh,
    output logic                               CC_LIVES_MANAGER_gameover_OutHigh
);

    localparam int W  = LIVES_COUNTER_DATAWIDTH;
    localparam int TW = $clog2(RESPAWN_CYCLES + 1);

    localparam logic [W-1:0]  initCount = W'(LIVES_INIT);
    localparam logic [W-1:0]  maxCount  = W'(LIVES_MAX);
    localparam logic [W-1:0]  lowCount  = W'(LOW_THRESHOLD);
    localparam logic [W-1:0]  oneCount  = W'(1);
    localparam logic [TW-1:0] timerLoad = TW'(RESPAWN_CYCLES - 1);

    logic              clk;
    logic              deathEvent;
    logic              bonusEvent;
    logic [W-1:0]      count;
    logic [W-1:0]      countInc;
    logic [TW-1:0]     timer;
    livesState_t       state;

    assign clk = CC_LIVES_MANAGER_CLOCK_50;

    cc_edge_detector deathEdge (
        .clk   (clk),
        .reset (CC_LIVES_MANAGER_RESET_InHigh),
        .level (CC_LIVES_MANAGER_death_InHigh),
        .pulse (deathEvent)
    );

    cc_edge_detector bonusEdge (
        .clk   (clk),
        .reset (CC_LIVES_MANAGER_RESET_InHigh),
        .level (CC_LIVES_MANAGER_bonus_InHigh),
        .pulse (bonusEvent)
    );

    assign countInc = (count >= maxCount) ? maxCount : count + oneCount;

    always_ff @(posedge clk) begin
        if (CC_LIVES_MANAGER_RESET_InHigh || CC_LIVES_MANAGER_restart_InHigh) begin
            count <= initCount;
            state <= ST_PLAYING;
            timer <= '0;
        end else begin
            unique case (state)
                ST_PLAYING: begin
                    if (deathEvent && !bonusEvent) begin
                        if (count <= oneCount) begin
                            count <= '0;
                            state <= ST_GAMEOVER;
                        end else begin
                            count <= count - oneCount;
                            state <= ST_HIT;
                            timer <= timerLoad;
                        end
                    end else if (deathEvent && bonusEvent) begin
                        // A simultaneous bonus cancels the lost life, but the hit still counts.
                        state <= ST_HIT;
                        timer <= timerLoad;
                    end else if (bonusEvent) begin
                        count <= countInc;
                    end
                end
                ST_HIT: begin
                    if (bonusEvent) begin
                        count <= countInc;
                    end
                    if (timer == '0) begin
                        state <= ST_PLAYING;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GAMEOVER: begin
                    count <= '0;
                end
                default: begin
                    state <= ST_PLAYING;
                end
            endcase
        end
    end

    assign CC_LIVES_MANAGER_lives_Out        = count;
    assign CC_LIVES_MANAGER_alive_OutHigh    = (count != '0);
    assign CC_LIVES_MANAGER_low_OutHigh      = (count != '0) && (count <= lowCount);
    assign CC_LIVES_MANAGER_respawn_OutHigh  = (state == ST_HIT);
    assign CC_LIVES_MANAGER_gameover_OutHigh = (state == ST_GAMEOVER);

endmodule

// File: tb/tb_cc_lives_manager.sv
// Directed bench for cc_lives_manager with a 4-cycle respawn window.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cc_lives_manager;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       restart = 1'b0;
    logic       death = 1'b0;
    logic       bonus = 1'b0;
    logic [2:0] lives;
    logic       alive;
    logic       low;
    logic       respawn;
    logic       gameover;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    cc_lives_manager #(
        .LIVES_COUNTER_DATAWIDTH (3),
        .LIVES_INIT              (3),
        .LIVES_MAX               (7),
        .LOW_THRESHOLD           (1),
        .RESPAWN_CYCLES          (4)
    ) dut (
        .CC_LIVES_MANAGER_CLOCK_50         (clk),
        .CC_LIVES_MANAGER_RESET_InHigh     (rst),
        .CC_LIVES_MANAGER_restart_InHigh   (restart),
        .CC_LIVES_MANAGER_death_InHigh     (death),
        .CC_LIVES_MANAGER_bonus_InHigh     (bonus),
        .CC_LIVES_MANAGER_lives_Out        (lives),
        .CC_LIVES_MANAGER_alive_OutHigh    (alive),
        .CC_LIVES_MANAGER_low_OutHigh      (low),
        .CC_LIVES_MANAGER_respawn_OutHigh  (respawn),
        .CC_LIVES_MANAGER_gameover_OutHigh (gameover)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        death = 1'b0;
        bonus = 1'b0;
        restart = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (lives !== 3'd3) begin
            errors++;
            $display("FAIL reset_lives: got %0d expected 3", lives);
        end
        checks++;
        if ({alive, low, respawn, gameover} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 1000", {alive, low, respawn, gameover});
        end
        tick();
        checks++;
        if (lives !== 3'd3 || respawn !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got lives=%0d respawn=%b expected 3/0", lives, respawn);
        end
    endtask

    task automatic test_death_held();
        int hiCount;
        doReset();
        death = 1'b1;
        tick();
        checks++;
        if (lives !== 3'd2 || respawn !== 1'b1) begin
            errors++;
            $display("FAIL held_first: got lives=%0d respawn=%b expected 2/1", lives, respawn);
        end
        hiCount = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (respawn === 1'b1) hiCount++;
        end
        checks++;
        if (hiCount !== 4) begin
            errors++;
            $display("FAIL held_respawn_len: got %0d expected 4", hiCount);
        end
        checks++;
        if (lives !== 3'd2 || respawn !== 1'b0) begin
            errors++;
            $display("FAIL held_no_redec: got lives=%0d respawn=%b expected 2/0", lives, respawn);
        end
        death = 1'b0;
        tick();
    endtask

    task automatic test_hit_window();
        doReset();
        death = 1'b1;
        tick();
        death = 1'b0;
        tick();
        death = 1'b1;
        tick();
        checks++;
        if (lives !== 3'd2 || respawn !== 1'b1) begin
            errors++;
            $display("FAIL hit_death_ignored: got lives=%0d respawn=%b expected 2/1", lives, respawn);
        end
        death = 1'b0;
        bonus = 1'b1;
        tick();
        checks++;
        if (lives !== 3'd3 || respawn !== 1'b1) begin
            errors++;
            $display("FAIL hit_bonus: got lives=%0d respawn=%b expected 3/1", lives, respawn);
        end
        bonus = 1'b0;
        tick();
        checks++;
        if (lives !== 3'd3 || respawn !== 1'b0) begin
            errors++;
            $display("FAIL hit_exit: got lives=%0d respawn=%b expected 3/0", lives, respawn);
        end
    endtask

    task automatic test_game_over();
        logic [2:0] expLives [3] = '{3'd2, 3'd1, 3'd0};
        logic       expLow   [3] = '{1'b0, 1'b1, 1'b0};
        doReset();
        for (int i = 0; i < 3; i++) begin
            death = 1'b1;
            tick();
            death = 1'b0;
            checks++;
            if (lives !== expLives[i] || low !== expLow[i]) begin
                errors++;
                $display("FAIL death_%0d: got lives=%0d low=%b expected %0d/%b",
                         i, lives, low, expLives[i], expLow[i]);
            end
            repeat (4) tick();
        end
        checks++;
        if ({alive, respawn, gameover} !== 3'b001) begin
            errors++;
            $display("FAIL gameover_flags: got %b expected 001", {alive, respawn, gameover});
        end
        bonus = 1'b1;
        tick();
        bonus = 1'b0;
        tick();
        death = 1'b1;
        tick();
        death = 1'b0;
        tick();
        checks++;
        if (lives !== 3'd0 || gameover !== 1'b1) begin
            errors++;
            $display("FAIL gameover_hold: got lives=%0d gameover=%b expected 0/1", lives, gameover);
        end
    endtask

    task automatic test_bonus_saturation();
        logic [2:0] expLives [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        doReset();
        for (int i = 0; i < 5; i++) begin
            bonus = 1'b1;
            tick();
            bonus = 1'b0;
            checks++;
            if (lives !== expLives[i]) begin
                errors++;
                $display("FAIL bonus_%0d: got %0d expected %0d", i, lives, expLives[i]);
            end
            tick();
        end
        death = 1'b1;
        bonus = 1'b1;
        tick();
        death = 1'b0;
        bonus = 1'b0;
        checks++;
        if (lives !== 3'd7 || respawn !== 1'b1) begin
            errors++;
            $display("FAIL death_bonus_same: got lives=%0d respawn=%b expected 7/1", lives, respawn);
        end
        repeat (4) tick();
        checks++;
        if (lives !== 3'd7 || respawn !== 1'b0) begin
            errors++;
            $display("FAIL death_bonus_exit: got lives=%0d respawn=%b expected 7/0", lives, respawn);
        end
    endtask

    task automatic test_restart();
        doReset();
        for (int i = 0; i < 3; i++) begin
            death = 1'b1;
            tick();
            death = 1'b0;
            repeat (4) tick();
        end
        checks++;
        if (gameover !== 1'b1) begin
            errors++;
            $display("FAIL restart_setup: got gameover=%b expected 1", gameover);
        end
        death = 1'b1;
        restart = 1'b1;
        tick();
        checks++;
        if (lives !== 3'd3 || {alive, respawn, gameover} !== 3'b100) begin
            errors++;
            $display("FAIL restart_load: got lives=%0d flags=%b expected 3/100",
                     lives, {alive, respawn, gameover});
        end
        restart = 1'b0;
        tick();
        tick();
        checks++;
        if (lives !== 3'd3 || respawn !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_edge: got lives=%0d respawn=%b expected 3/0", lives, respawn);
        end
        death = 1'b0;
        tick();
        death = 1'b1;
        tick();
        death = 1'b0;
        checks++;
        if (lives !== 3'd2) begin
            errors++;
            $display("FAIL restart_prep: got %0d expected 2", lives);
        end
        rst = 1'b1;
        restart = 1'b1;
        tick();
        rst = 1'b0;
        restart = 1'b0;
        checks++;
        if (lives !== 3'd3 || {alive, low, respawn, gameover} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_and_restart: got lives=%0d flags=%b expected 3/1000",
                     lives, {alive, low, respawn, gameover});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_death_held();
        test_hit_window();
        test_game_over();
        test_bonus_saturation();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
